// File: rtl/spi_slave.sv
// spi_slave: SPI endpoint that receives a FRAME_BITS command LSB-first and returns a buffered REPLY_BITS reply LSB-first.
module spi_slave #(
  parameter int FRAME_BITS = 14,
  parameter int REPLY_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  input  logic [REPLY_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun
);
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;
  state_t state, state_n;
  logic [4:0] cnt;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [REPLY_BITS-1:0] rep, rep_n, buf_q;
  logic full, start, shift_en, last, abort, load;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = CS ? IDLE : SHIFT;
      SHIFT:   state_n = CS ? IDLE : (cnt == 5'(FRAME_BITS-1)) ? WAIT_CS : SHIFT;
      WAIT_CS: state_n = CS ? IDLE : WAIT_CS;
      default: state_n = IDLE;
    endcase
  end
  // In IDLE the reply register mirrors the buffer so bit 0 is on MISO before the first sample edge.
  always_comb begin
    start    = state == IDLE && !CS;
    shift_en = state == SHIFT && !CS;
    last     = shift_en && cnt == 5'(FRAME_BITS-1);
    abort    = state == SHIFT && CS;
    load     = tx_valid && !full;
    rep_n    = state == IDLE ? (full ? (start ? buf_q >> 1 : buf_q) : '0) : shift_en ? rep >> 1 : '0;
  end
  assign MISO     = rep[0];
  assign tx_ready = !full;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt         <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      rep         <= '0;
      buf_q       <= '0;
      full        <= 1'b0;
    end else begin
      rep         <= rep_n;
      rx_valid    <= last;
      frame_err   <= abort;
      tx_underrun <= start && !full;
      cnt         <= start ? 5'd1 : (shift_en && !last) ? cnt + 5'd1 : 5'd0;
      if (start || shift_en) rx_shift <= {MOSI, rx_shift[FRAME_BITS-1:1]};
      if (last) rx_data <= {MOSI, rx_shift[FRAME_BITS-1:1]};
      if (load) buf_q <= tx_data;
      // a load on the frame-start edge of an empty buffer stays for the next frame
      full        <= load | (full & !start);
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed scenario tests for spi_slave with hand-computed expectations.
module tb_spi_slave;
  logic clk = 1'b0, rst = 1'b0, CS = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic MISO, rx_valid, frame_err, tx_ready, tx_underrun;
  logic [13:0] rx_data;
  int tests = 0, fails = 0;
  int nv, ne, nu;
  logic pre, u_first;
  logic [19:0] mi;

  spi_slave #(.FRAME_BITS(14), .REPLY_BITS(8)) dut (
    .clk(clk), .rst(rst), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic cs, input logic mosi);
    CS = cs;
    MOSI = mosi;
    pre = MISO;
    @(posedge clk);
    #1;
    nv += int'(rx_valid);
    ne += int'(frame_err);
    nu += int'(tx_underrun);
    @(negedge clk);
  endtask

  task automatic frame(input logic [13:0] d, input int n, input logic ld, input logic [7:0] lv);
    nv = 0; ne = 0; nu = 0; mi = '0; u_first = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == 0 && ld) begin tx_valid = 1'b1; tx_data = lv; end
      cyc(1'b0, i < 14 ? d[i] : 1'b1);
      mi[i] = pre;
      if (i == 0) u_first = tx_underrun;
      tx_valid = 1'b0;
    end
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
  endtask

  task automatic load(input logic [7:0] v);
    tx_valid = 1'b1;
    tx_data = v;
    cyc(1'b1, 1'b0);
    tx_valid = 1'b0;
    cyc(1'b1, 1'b0);
  endtask

  task automatic test_reset;
    #1;
    tests++; if (MISO !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b want 0", MISO); end
    tests++; if (rx_data !== 14'h0) begin fails++; $display("FAIL reset_rx_data: got %h want 0000", rx_data); end
    tests++; if ({rx_valid, frame_err, tx_underrun} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b want 000", {rx_valid, frame_err, tx_underrun}); end
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    load(8'hA5);
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL basic_loaded: tx_ready got %b want 0", tx_ready); end
    frame(14'h2B3C, 14, 1'b0, 8'h00);
    tests++; if (rx_data !== 14'h2B3C) begin fails++; $display("FAIL basic_rx_data: got %h want 2b3c", rx_data); end
    tests++; if (nv != 1 || ne != 0 || nu != 0) begin fails++; $display("FAIL basic_pulses: got v%0d e%0d u%0d want v1 e0 u0", nv, ne, nu); end
    tests++; if (mi[13:0] !== 14'h00A5) begin fails++; $display("FAIL basic_miso: got %h want 00a5", mi[13:0]); end
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL basic_tx_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_underrun;
    frame(14'h1234, 14, 1'b0, 8'h00);
    tests++; if (u_first !== 1'b1 || nu != 1) begin fails++; $display("FAIL underrun_pulse: got first %b count %0d want 1 1", u_first, nu); end
    tests++; if (mi[13:0] !== 14'h0) begin fails++; $display("FAIL underrun_miso: got %h want 0000", mi[13:0]); end
    tests++; if (rx_data !== 14'h1234 || nv != 1) begin fails++; $display("FAIL underrun_rx: got %h v%0d want 1234 v1", rx_data, nv); end
  endtask

  task automatic test_abort;
    frame(14'h0FFF, 9, 1'b0, 8'h00);
    tests++; if (ne != 1 || nv != 0) begin fails++; $display("FAIL abort_pulses: got e%0d v%0d want e1 v0", ne, nv); end
    tests++; if (rx_data !== 14'h1234) begin fails++; $display("FAIL abort_rx_hold: got %h want 1234", rx_data); end
    frame(14'h0001, 14, 1'b0, 8'h00);
    tests++; if (rx_data !== 14'h0001 || nv != 1 || ne != 0) begin fails++; $display("FAIL abort_next: got %h v%0d e%0d want 0001 v1 e0", rx_data, nv, ne); end
  endtask

  task automatic test_long_cs;
    frame(14'h2AAA, 20, 1'b0, 8'h00);
    tests++; if (rx_data !== 14'h2AAA || nv != 1 || ne != 0) begin fails++; $display("FAIL long_rx: got %h v%0d e%0d want 2aaa v1 e0", rx_data, nv, ne); end
    frame(14'h0155, 14, 1'b0, 8'h00);
    tests++; if (rx_data !== 14'h0155 || nv != 1) begin fails++; $display("FAIL long_next: got %h v%0d want 0155 v1", rx_data, nv); end
  endtask

  task automatic test_same_edge;
    frame(14'h0AAA, 14, 1'b1, 8'hC3);
    tests++; if (nu != 1 || mi[7:0] !== 8'h00) begin fails++; $display("FAIL same_edge_first: got u%0d miso %h want u1 00", nu, mi[7:0]); end
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL same_edge_buffered: tx_ready got %b want 0", tx_ready); end
    frame(14'h0123, 14, 1'b0, 8'h00);
    tests++; if (nu != 0 || mi[13:0] !== 14'h00C3) begin fails++; $display("FAIL same_edge_second: got u%0d miso %h want u0 00c3", nu, mi[13:0]); end
    tests++; if (rx_data !== 14'h0123 || tx_ready !== 1'b1) begin fails++; $display("FAIL same_edge_rx: got %h rdy %b want 0123 1", rx_data, tx_ready); end
  endtask

  task automatic test_reset_mid;
    logic [13:0] d = 14'h1555;
    load(8'hFF);
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin tx_valid = 1'b1; tx_data = 8'h11; end
      cyc(1'b0, d[i]);
      tx_valid = 1'b0;
    end
    tests++; if (MISO !== 1'b1 || tx_ready !== 1'b0) begin fails++; $display("FAIL mid_pre: got miso %b rdy %b want 1 0", MISO, tx_ready); end
    rst = 1'b0;
    #1;
    tests++; if (MISO !== 1'b0 || rx_data !== 14'h0 || tx_ready !== 1'b1) begin fails++; $display("FAIL mid_reset: got miso %b rx %h rdy %b want 0 0000 1", MISO, rx_data, tx_ready); end
    tests++; if ({rx_valid, frame_err, tx_underrun} !== 3'b000) begin fails++; $display("FAIL mid_reset_pulses: got %b want 000", {rx_valid, frame_err, tx_underrun}); end
    @(negedge clk);
    rst = 1'b1;
    frame(14'h3FFF, 14, 1'b0, 8'h00);
    tests++; if (rx_data !== 14'h3FFF || nv != 1 || ne != 0 || nu != 1) begin fails++; $display("FAIL mid_after: got %h v%0d e%0d u%0d want 3fff v1 e0 u1", rx_data, nv, ne, nu); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_underrun;
    test_abort;
    test_long_cs;
    test_same_edge;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
